bcd_stopwatch: RTL and testbench
================================

// Module: bcd_stopwatch
// PURPOSE
//   MM:SS BCD stopwatch consuming the 1 Hz single-cycle tick from the jump-counter
//   frequency divider. Start/stop and clear controls drive a 3-state FSM.
//   Output is four packed BCD digits for the seven-segment display driver.
// PARAMETERS
//   LIMIT_BCD  16'h5959  last count before wrap, {m10,m1,s10,s1}; s10<=5, all digits<=9
// PORTS
//   clk         in   1   system clock; all state changes on posedge
//   rst         in   1   asynchronous, active-high reset
//   tick        in   1   count enable, one clk cycle wide (from divider)
//   start_stop  in   1   one-cycle pulse: toggles run/pause
//   clear       in   1   one-cycle pulse: zero count, return to IDLE
//   lap         in   1   one-cycle pulse: freeze/unfreeze display (LAP_EN only)
//   digits      out  16  {m10,m1,s10,s1} BCD, registered
//   running     out  1   1 while FSM in RUN, registered
//   wrap        out  1   one-cycle pulse when count wraps LIMIT_BCD -> 0000
// BEHAVIOUR
//   Reset (async, rst=1): count=16'h0000, digits=16'h0000, running=0, wrap=0,
//     state=IDLE, lap hold cleared. Outputs stay at reset values while rst=1.
//   FSM states: IDLE (count 0000), RUN, PAUSE.
//     IDLE  --start_stop--> RUN
//     RUN   --start_stop--> PAUSE
//     PAUSE --start_stop--> RUN
//     any   --clear-------> IDLE, count=0000, wrap=0 next cycle
//   Priority in one cycle: clear > start_stop > tick.
//   Tick is counted only if the registered state is RUN in that cycle:
//     RUN + start_stop + tick: count increments, next state PAUSE.
//     IDLE/PAUSE + start_stop + tick: no increment, next state RUN.
//     clear + tick (any state): no increment; count=0000.
//   Increment (1 cycle latency, tick at edge N -> digits updated after edge N):
//     s1 0..9, carry to s10 0..5, carry to m1 0..9, carry to m10 0..9.
//     If count==LIMIT_BCD: next count=0000, wrap=1 for exactly one cycle.
//     Otherwise wrap=0. No non-BCD value ever appears on digits.
//   running = (state==RUN), updates same edge as state.
//   digits mirrors count (subject to LAP_EN hold below).
//   start_stop/clear/lap are assumed one-cycle pulses; held high = toggle every cycle.
// CONFIGURATION
//   LAP_EN defined:
//     lap pulse while not holding: digits freezes at current count; counting continues.
//     lap pulse while holding: digits resumes tracking count next cycle.
//     clear or rst releases hold; digits=0000. lap in IDLE is ignored.
//   LAP_EN undefined: lap port present but ignored; digits always equals count.
// TESTING
//   rst=1 mid-count at 12:34 -> digits=0000, running=0, wrap=0 immediately (async).
//   start_stop, then 60 ticks -> digits 0000..0059 then 0100; running=1 throughout.
//   preload via ticks to 59:59 (LIMIT_BCD=5959), 1 tick -> digits=0000, wrap=1 one cycle.
//   RUN at 0007, start_stop -> PAUSE; 5 ticks -> digits stays 0007; start_stop, tick -> 0008.
//   RUN at 0030, clear+start_stop+tick same cycle -> digits=0000, state IDLE, running=0.
//   LAP_EN: RUN at 0010, lap, 5 ticks -> digits=0010; lap -> digits=0015 next cycle.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch driven by a 1 Hz tick, with IDLE/RUN/PAUSE control FSM.
// Optional lap-hold display freeze is enabled by defining LAP_EN.
module bcd_stopwatch #(
  parameter logic [15:0] LIMIT_BCD = 16'h5959
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] digits_q, digits_d;
  logic        running_q, running_d;
  logic        wrap_q, wrap_d;
  logic        hold_q, hold_d;

  // Ripple the carry up through s1 (0..9), s10 (0..5), m1 (0..9), m10 (0..9).
  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] n;
    n = c;
    if (c[3:0] != 4'd9) n[3:0] = c[3:0] + 4'd1;
    else begin
      n[3:0] = 4'd0;
      if (c[7:4] != 4'd5) n[7:4] = c[7:4] + 4'd1;
      else begin
        n[7:4] = 4'd0;
        if (c[11:8] != 4'd9) n[11:8] = c[11:8] + 4'd1;
        else begin
          n[11:8]  = 4'd0;
          n[15:12] = (c[15:12] != 4'd9) ? c[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    hold_d  = hold_q;
    if (clear) begin
      state_d = IDLE;
      count_d = 16'h0000;
      hold_d  = 1'b0;
    end else begin
      // Tick qualification uses the registered state, so RUN+start_stop still counts.
      if (tick && state_q == RUN) begin
        if (count_q == LIMIT_BCD) begin
          count_d = 16'h0000;
          wrap_d  = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
        end
      end
      if (start_stop) state_d = (state_q == RUN) ? PAUSE : RUN;
`ifdef LAP_EN
      if (lap && state_q != IDLE) hold_d = ~hold_q;
`endif
    end
    digits_d  = hold_d ? digits_q : count_d;
    running_d = (state_d == RUN);
  end

`ifndef LAP_EN
  logic unused_lap;
  assign unused_lap = lap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 16'h0000;
      digits_q  <= 16'h0000;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      hold_q    <= hold_d;
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch; a seconds-based model fills a scoreboard
// queue per driven cycle, popped and compared after the clock edge.
module tb_bcd_stopwatch;
  logic        clk = 1'b0;
  logic        rst, tick, start_stop, clear, lap;
  logic [15:0] digits;
  logic        running, wrap;

  bcd_stopwatch dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .digits(digits), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Model: elapsed seconds, state 0=IDLE 1=RUN 2=PAUSE, lap hold
  int m_sec, m_st, m_disp;
  bit m_hold, m_wrap;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_st = 0; m_disp = 0; m_hold = 0; m_wrap = 0;
  endtask

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit t, input bit ss, input bit cl, input bit lp, input string tag);
    exp_t e;
    m_wrap = 0;
    if (cl) begin
      m_st = 0; m_sec = 0; m_hold = 0;
    end else begin
      if (t && m_st == 1) begin
        if (m_sec == 3599) begin m_sec = 0; m_wrap = 1; end
        else m_sec++;
      end
`ifdef LAP_EN
      if (lp && m_st != 0) m_hold = !m_hold;
`endif
      if (ss) m_st = (m_st == 1) ? 2 : 1;
    end
    if (!m_hold) m_disp = m_sec;
    q.push_back('{{to_bcd(m_disp), m_st == 1, m_wrap}, tag});
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    #1;
    tick = 0; start_stop = 0; clear = 0; lap = 0;
    e = q.pop_front();
    chk(e.tag, {digits, running, wrap}, e.v);
  endtask

  initial begin
    rst = 1'b1; tick = 0; start_stop = 0; clear = 0; lap = 0;
    model_reset();
    #12;
    chk("reset_state", {digits, running, wrap}, 18'h0);
    @(posedge clk); #1 rst = 1'b0;

    // start, 60 ticks: 00:00 .. 00:59 then 01:00
    cyc(0, 1, 0, 0, "start");
    for (int i = 0; i < 60; i++) cyc(1, 0, 0, 0, "run60");
    chk("run60_end", {digits, running, wrap}, {16'h0100, 1'b1, 1'b0});

    // async reset mid-count at 12:34
    cyc(0, 0, 1, 0, "clr1");
    cyc(0, 1, 0, 0, "start2");
    for (int i = 0; i < 754; i++) cyc(1, 0, 0, 0, "to1234");
    chk("at1234", {digits, running, wrap}, {16'h1234, 1'b1, 1'b0});
    rst = 1'b1;
    #1;
    chk("async_rst", {digits, running, wrap}, 18'h0);
    @(posedge clk); #1;
    chk("rst_held", {digits, running, wrap}, 18'h0);
    rst = 1'b0;
    model_reset();

    // wrap at 59:59
    cyc(0, 1, 0, 0, "start3");
    for (int i = 0; i < 3599; i++) cyc(1, 0, 0, 0, "to5959");
    chk("at5959", {digits, running, wrap}, {16'h5959, 1'b1, 1'b0});
    cyc(1, 0, 0, 0, "wrap_tick");
    chk("wrap_pulse", {digits, running, wrap}, {16'h0000, 1'b1, 1'b1});
    cyc(0, 0, 0, 0, "wrap_end");
    chk("wrap_one_cycle", {digits, running, wrap}, {16'h0000, 1'b1, 1'b0});

    // pause holds count
    cyc(0, 0, 1, 0, "clr2");
    cyc(0, 1, 0, 0, "start4");
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, "to0007");
    cyc(0, 1, 0, 0, "pause");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, "paused_tick");
    chk("paused_0007", {digits, running, wrap}, {16'h0007, 1'b0, 1'b0});
    cyc(0, 1, 0, 0, "resume");
    cyc(1, 0, 0, 0, "resume_tick");
    chk("resumed_0008", {digits, running, wrap}, {16'h0008, 1'b1, 1'b0});

    // RUN + start_stop + tick counts then pauses; PAUSE + ss + tick doesn't count
    cyc(1, 1, 0, 0, "run_ss_tick");
    chk("run_ss_tick_0009", {digits, running, wrap}, {16'h0009, 1'b0, 1'b0});
    cyc(1, 1, 0, 0, "pause_ss_tick");
    chk("pause_ss_tick_0009", {digits, running, wrap}, {16'h0009, 1'b1, 1'b0});

    // clear beats start_stop and tick
    cyc(0, 0, 1, 0, "clr3");
    cyc(0, 1, 0, 0, "start5");
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, "to0030");
    cyc(1, 1, 1, 0, "clr_ss_tick");
    chk("clr_priority", {digits, running, wrap}, 18'h0);
    cyc(1, 0, 0, 0, "idle_tick");
    chk("idle_no_count", {digits, running, wrap}, 18'h0);

    // held start_stop toggles every cycle
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, "held_ss");

    // lap hold (ignored when the feature is compiled out)
    cyc(0, 0, 1, 0, "clr4");
    cyc(0, 0, 0, 1, "lap_idle");
    cyc(0, 1, 0, 0, "start6");
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, "to0010");
    cyc(0, 0, 0, 1, "lap_on");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, "lap_ticks");
`ifdef LAP_EN
    chk("lap_frozen", {digits, running, wrap}, {16'h0010, 1'b1, 1'b0});
`else
    chk("lap_ignored", {digits, running, wrap}, {16'h0015, 1'b1, 1'b0});
`endif
    cyc(0, 0, 0, 1, "lap_off");
    chk("lap_release_0015", {digits, running, wrap}, {16'h0015, 1'b1, 1'b0});
    cyc(0, 0, 0, 1, "lap_on2");
    cyc(1, 0, 1, 0, "clr_releases_lap");
    cyc(0, 1, 0, 0, "start7");
    cyc(1, 0, 0, 0, "after_clr_tick");
    chk("lap_cleared_0001", {digits, running, wrap}, {16'h0001, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
